// File: rtl/video_timing_pkg.sv
// Shared video timing constants and counter widths used by the video_out block.
package video_timing_pkg;

    // VDP pixel strobes per VDP line, also display clocks per display line
    localparam int H_TOTAL      = 1368;
    // VDP lines per frame for each standard
    localparam int V_TOTAL_NTSC = 524;
    localparam int V_TOTAL_PAL  = 626;

    // Counter widths sized for the largest standard (PAL)
    localparam int HC_W = 11;   // vdp_hcounter, 0..1367
    localparam int VC_W = 10;   // vdp_vcounter, 0..625
    localparam int DH_W = 11;   // h_cnt, 0..1367
    localparam int DV_W = 11;   // v_cnt, 0..1251

    // Index of the last VDP line of a frame for the selected standard
    function automatic logic [VC_W-1:0] last_line(input logic pal,
                                                  input int   ntsc_total,
                                                  input int   pal_total);
        if (pal) begin
            return VC_W'(pal_total - 1);
        end
        return VC_W'(ntsc_total - 1);
    endfunction

endpackage

// File: rtl/video_sync_window.sv
// Registered window comparator turning display counters into LCD hs/vs/de.
module video_sync_window
    import video_timing_pkg::*;
#(
    parameter int HS_WIDTH    = 96,
    parameter int VS_WIDTH    = 2,
    parameter int H_DE_START  = 200,
    parameter int H_DE_WIDTH  = 1024,
    parameter int V_DE_START  = 40,
    parameter int V_DE_HEIGHT = 960
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [DH_W-1:0] h_cnt,
    input  logic [DV_W-1:0] v_cnt,
    output logic            hs,
    output logic            vs,
    output logic            de
);

    // One extra bit so window ends past the counter range cannot wrap
    localparam int HX_W = DH_W + 1;
    localparam int VX_W = DV_W + 1;

    localparam logic [HX_W-1:0] HS_END   = HX_W'(HS_WIDTH);
    localparam logic [VX_W-1:0] VS_END   = VX_W'(VS_WIDTH);
    localparam logic [HX_W-1:0] H_DE_LO  = HX_W'(H_DE_START);
    localparam logic [HX_W-1:0] H_DE_HI  = HX_W'(H_DE_START + H_DE_WIDTH);
    localparam logic [VX_W-1:0] V_DE_LO  = VX_W'(V_DE_START);
    localparam logic [VX_W-1:0] V_DE_HI  = VX_W'(V_DE_START + V_DE_HEIGHT);

    logic [HX_W-1:0] h_ext;
    logic [VX_W-1:0] v_ext;
    logic            hs_next;
    logic            vs_next;
    logic            de_next;

    // Window decode of the current counter values; a vertical window that
    // extends past the frame simply never sees its tail lines
    always_comb begin
        h_ext   = {1'b0, h_cnt};
        v_ext   = {1'b0, v_cnt};
        hs_next = (h_ext < HS_END);
        vs_next = (v_ext < VS_END);
        de_next = (h_ext >= H_DE_LO) && (h_ext < H_DE_HI) &&
                  (v_ext >= V_DE_LO) && (v_ext < V_DE_HI);
    end

    // Register the decode so sync outputs are glitch-free, one clk behind
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs <= 1'b0;
            vs <= 1'b0;
            de <= 1'b0;
        end else begin
            hs <= hs_next;
            vs <= vs_next;
            de <= de_next;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Master video timing: VDP pixel strobe and counters, scan-doubled display
// counters phase-locked to the VDP line, and registered LCD sync/DE.
module video_timing_gen #(
    parameter int H_TOTAL      = video_timing_pkg::H_TOTAL,
    parameter int V_TOTAL_NTSC = video_timing_pkg::V_TOTAL_NTSC,
    parameter int V_TOTAL_PAL  = video_timing_pkg::V_TOTAL_PAL,
    parameter int HS_WIDTH     = 96,
    parameter int VS_WIDTH     = 2,
    parameter int H_DE_START   = 200,
    parameter int H_DE_WIDTH   = 1024,
    parameter int V_DE_START   = 40,
    parameter int V_DE_HEIGHT  = 960
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              pal_mode,
    output logic                              enable,
    output logic [video_timing_pkg::HC_W-1:0] vdp_hcounter,
    output logic [video_timing_pkg::VC_W-1:0] vdp_vcounter,
    output logic [video_timing_pkg::DH_W-1:0] h_cnt,
    output logic [video_timing_pkg::DV_W-1:0] v_cnt,
    output logic                              lcd_hs,
    output logic                              lcd_vs,
    output logic                              lcd_de,
    output logic                              frame_start
);

    import video_timing_pkg::*;

    localparam logic [HC_W-1:0] VDP_H_LAST  = HC_W'(H_TOTAL - 1);
    localparam logic [DH_W-1:0] DISP_H_LAST = DH_W'(H_TOTAL - 1);

    logic            pal_latched;
    logic [VC_W-1:0] last_vline;
    logic            line_end;
    logic            frame_end;
    logic            h_wrap;

    // Wrap conditions for this edge; the display line restarts whenever the
    // VDP line does, which keeps h_cnt locked to the VDP line phase
    always_comb begin
        last_vline = last_line(pal_latched, V_TOTAL_NTSC, V_TOTAL_PAL);
        line_end   = enable && (vdp_hcounter == VDP_H_LAST);
        frame_end  = line_end && (vdp_vcounter == last_vline);
        h_wrap     = line_end || (h_cnt == DISP_H_LAST);
    end

    // Pixel strobe at half the system clock, high after the first edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable <= 1'b0;
        end else begin
            enable <= ~enable;
        end
    end

    // VDP horizontal position, stepping once per pixel strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vdp_hcounter <= '0;
        end else if (enable) begin
            if (line_end) begin
                vdp_hcounter <= '0;
            end else begin
                vdp_hcounter <= vdp_hcounter + 11'd1;
            end
        end
    end

    // VDP line counter, stepping at the end of each VDP line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vdp_vcounter <= '0;
        end else if (line_end) begin
            if (frame_end) begin
                vdp_vcounter <= '0;
            end else begin
                vdp_vcounter <= vdp_vcounter + 10'd1;
            end
        end
    end

    // Standard selection only changes at a frame boundary, never mid-frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pal_latched <= 1'b0;
        end else if (frame_end) begin
            pal_latched <= pal_mode;
        end
    end

    // Frame start marker, high while the counters first show line 0 pixel 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_end;
        end
    end

    // Display horizontal position, one step per clk, two lines per VDP line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    // Display line counter; the VDP frame wrap overrides the line step
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_cnt <= '0;
        end else if (frame_end) begin
            v_cnt <= '0;
        end else if (h_wrap) begin
            v_cnt <= v_cnt + 11'd1;
        end
    end

    video_sync_window #(
        .HS_WIDTH    (HS_WIDTH),
        .VS_WIDTH    (VS_WIDTH),
        .H_DE_START  (H_DE_START),
        .H_DE_WIDTH  (H_DE_WIDTH),
        .V_DE_START  (V_DE_START),
        .V_DE_HEIGHT (V_DE_HEIGHT)
    ) u_sync_window (
        .clk     (clk),
        .reset_n (reset_n),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .hs      (lcd_hs),
        .vs      (lcd_vs),
        .de      (lcd_de)
    );

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen. Full line length is kept; frame
// heights are shortened (6 NTSC / 8 PAL VDP lines) so whole frames fit a
// short run, with a DE window (display lines 4..13) that overruns the
// NTSC frame but fits inside the PAL frame.
module tb_video_timing_gen;

    typedef struct {
        int   cyc;
        logic pal;
        logic en;
        int   hc;
        int   vc;
        int   hcnt;
        int   vcnt;
        logic hs;
        logic vs;
        logic de;
        logic fs;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        pal_mode;
    logic        enable;
    logic [10:0] vdp_hcounter;
    logic [9:0]  vdp_vcounter;
    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        lcd_hs;
    logic        lcd_vs;
    logic        lcd_de;
    logic        frame_start;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    video_timing_gen #(
        .V_TOTAL_NTSC (6),
        .V_TOTAL_PAL  (8),
        .V_DE_START   (4),
        .V_DE_HEIGHT  (10)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pal_mode     (pal_mode),
        .enable       (enable),
        .vdp_hcounter (vdp_hcounter),
        .vdp_vcounter (vdp_vcounter),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .lcd_hs       (lcd_hs),
        .lcd_vs       (lcd_vs),
        .lcd_de       (lcd_de),
        .frame_start  (frame_start)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_vec(input int c, input logic p, input logic e,
                           input int hc, input int vc, input int hcnt, input int vcnt,
                           input logic hs, input logic vs, input logic de, input logic fs);
        vec_t v;
        v.cyc = c; v.pal = p; v.en = e; v.hc = hc; v.vc = vc;
        v.hcnt = hcnt; v.vcnt = vcnt; v.hs = hs; v.vs = vs; v.de = de; v.fs = fs;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drive pal_mode, then step to the given edge count since reset release
    task automatic applyStimulus(input logic p, input int target);
        pal_mode = p;
        while (cyc < target) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic check_vec(input int i);
        string t;
        t = $sformatf("v%0d_k%0d", i, vecs[i].cyc);
        checkOutput({t, "_enable"},       32'(enable),       32'(vecs[i].en));
        checkOutput({t, "_vdp_hcounter"}, 32'(vdp_hcounter), vecs[i].hc);
        checkOutput({t, "_vdp_vcounter"}, 32'(vdp_vcounter), vecs[i].vc);
        checkOutput({t, "_h_cnt"},        32'(h_cnt),        vecs[i].hcnt);
        checkOutput({t, "_v_cnt"},        32'(v_cnt),        vecs[i].vcnt);
        checkOutput({t, "_lcd_hs"},       32'(lcd_hs),       32'(vecs[i].hs));
        checkOutput({t, "_lcd_vs"},       32'(lcd_vs),       32'(vecs[i].vs));
        checkOutput({t, "_lcd_de"},       32'(lcd_de),       32'(vecs[i].de));
        checkOutput({t, "_frame_start"},  32'(frame_start),  32'(vecs[i].fs));
    endtask

    task automatic check_all_zero(input string t);
        checkOutput({t, "_enable"},       32'(enable),       0);
        checkOutput({t, "_vdp_hcounter"}, 32'(vdp_hcounter), 0);
        checkOutput({t, "_vdp_vcounter"}, 32'(vdp_vcounter), 0);
        checkOutput({t, "_h_cnt"},        32'(h_cnt),        0);
        checkOutput({t, "_v_cnt"},        32'(v_cnt),        0);
        checkOutput({t, "_lcd_hs"},       32'(lcd_hs),       0);
        checkOutput({t, "_lcd_vs"},       32'(lcd_vs),       0);
        checkOutput({t, "_lcd_de"},       32'(lcd_de),       0);
        checkOutput({t, "_frame_start"},  32'(frame_start),  0);
    endtask

    initial begin
        //       k      pal en  hc    vc  hcnt  vcnt hs vs de fs
        add_vec(1,     0, 1, 0,    0,  1,    0,   1, 1, 0, 0);
        add_vec(2,     0, 0, 1,    0,  2,    0,   1, 1, 0, 0);
        add_vec(3,     0, 1, 1,    0,  3,    0,   1, 1, 0, 0);
        add_vec(4,     0, 0, 2,    0,  4,    0,   1, 1, 0, 0);
        add_vec(96,    0, 0, 48,   0,  96,   0,   1, 1, 0, 0);
        add_vec(97,    0, 1, 48,   0,  97,   0,   0, 1, 0, 0);
        add_vec(1367,  0, 1, 683,  0,  1367, 0,   0, 1, 0, 0);
        add_vec(1368,  0, 0, 684,  0,  0,    1,   0, 1, 0, 0);
        add_vec(1369,  0, 1, 684,  0,  1,    1,   1, 1, 0, 0);
        add_vec(2735,  0, 1, 1367, 0,  1367, 1,   0, 1, 0, 0);
        add_vec(2736,  0, 0, 0,    1,  0,    2,   0, 1, 0, 0);
        add_vec(2737,  0, 1, 0,    1,  1,    2,   1, 0, 0, 0);
        // pal_mode rises mid-frame; this frame must still end after 6 lines
        add_vec(4605,  1, 1, 934,  1,  501,  3,   0, 0, 0, 0);
        add_vec(5672,  1, 0, 100,  2,  200,  4,   0, 0, 0, 0);
        add_vec(5673,  1, 1, 100,  2,  201,  4,   0, 0, 1, 0);
        add_vec(6696,  1, 0, 612,  2,  1224, 4,   0, 0, 1, 0);
        add_vec(6697,  1, 1, 612,  2,  1225, 4,   0, 0, 0, 0);
        add_vec(15549, 1, 1, 934,  5,  501,  11,  0, 0, 1, 0);
        add_vec(16415, 1, 1, 1367, 5,  1367, 11,  0, 0, 0, 0);
        add_vec(16416, 1, 0, 0,    0,  0,    0,   0, 0, 0, 1);
        add_vec(16417, 1, 1, 0,    0,  1,    0,   1, 1, 0, 0);
        // PAL frame: runs past line 5 and uses display lines 12..15
        add_vec(32832, 1, 0, 0,    6,  0,    12,  0, 0, 0, 0);
        add_vec(33033, 1, 1, 100,  6,  201,  12,  0, 0, 1, 0);
        add_vec(34701, 1, 1, 934,  6,  501,  13,  0, 0, 1, 0);
        add_vec(38303, 1, 1, 1367, 7,  1367, 15,  0, 0, 0, 0);
        add_vec(38304, 1, 0, 0,    0,  0,    0,   0, 0, 0, 1);
        add_vec(38305, 1, 1, 0,    0,  1,    0,   1, 1, 0, 0);

        reset_n  = 1'b0;
        pal_mode = 1'b0;
        #12;
        check_all_zero("in_reset");

        @(negedge clk);
        reset_n = 1'b1;
        cyc     = 0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].pal, vecs[i].cyc);
            check_vec(i);
        end

        // Mid-frame reset at VDP line 3, hcounter 700 of the PAL frame
        applyStimulus(1'b1, 47912);
        checkOutput("pre_reset_vdp_hcounter", 32'(vdp_hcounter), 700);
        checkOutput("pre_reset_vdp_vcounter", 32'(vdp_vcounter), 3);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("held_reset");

        @(negedge clk);
        reset_n = 1'b1;
        cyc     = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].pal, vecs[i].cyc);
            check_vec(i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
